stk_pipe_mem_head_ctrl: RTL and testbench

STK_PIPE_MEM_HEAD_CTRL -- requirements
Module: stk_pipe_mem_head_ctrl

---
 rtl/stk_pipe_mem_head_ctrl.sv | 155 +++++++++++++++
 tb/tb_stk_pipe_mem_head_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stk_pipe_mem_head_ctrl.sv
// stk_pipe_mem_head_ctrl
// Front-end controller for a single-port head-entry SRAM. After reset, and on
// every i_init pulse, it sweeps INIT_VAL into all N entries and holds off
// requests. Afterwards it passes one read or write per cycle straight to the
// SRAM and returns read data as a valid/data response with no backpressure.
//
// Optional build macro:
//   STK_PIPE_MEM_HEAD_CTRL_RSP_FLOP_EN -- adds one register stage on the read
//   response, so read latency becomes 2 cycles. Throughput is unchanged.
//   Left undefined, read data is taken straight from the SRAM output and the
//   read latency is 1 cycle.
module stk_pipe_mem_head_ctrl #(
  parameter int           W        = 10,
  parameter int           N        = 1024,
  parameter logic [W-1:0] INIT_VAL = 10'h000,
  localparam int          AW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          i_init,
  input  logic          i_req_vld,
  output logic          o_req_rdy,
  input  logic          i_req_wr,
  input  logic [AW-1:0] i_req_addr,
  input  logic [W-1:0]  i_req_din,
  output logic          o_rsp_vld,
  output logic [W-1:0]  o_rsp_dout,
  output logic          o_busy,
  output logic [AW-1:0] o_sram_addr,
  output logic [W-1:0]  o_sram_din,
  output logic          o_sram_ce,
  output logic          o_sram_oe,
  input  logic [W-1:0]  i_sram_dout
);

  // A single state bit holds both states, so no other encoding can be reached.
  localparam logic [0:0] ST_INIT   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] cnt;
  logic          last_entry;
  logic          accept_p0;
  logic          rd_vld_p0;
  logic          rd_vld_p1;
  logic          hold_oe;
  logic [AW-1:0] hold_addr;
  logic [W-1:0]  hold_din;

  assign last_entry = (cnt == AW'(N - 1));

  // An i_init pulse blocks that cycle's request. The request is not retried;
  // it has to be offered again after the sweep.
  assign o_busy    = (state == ST_INIT);
  assign o_req_rdy = (state == ST_ACTIVE) && !i_init;
  assign accept_p0 = i_req_vld && o_req_rdy;
  assign rd_vld_p0 = accept_p0 && !i_req_wr;

  // Drive the SRAM pins. During the sweep the controller writes one entry
  // per cycle. In ACTIVE an accepted request goes straight through. On idle
  // cycles the pins hold their last values, so the address and data buses
  // stop toggling. During reset, arst_n masks the chip enable immediately,
  // without waiting for a clock edge.
  always_comb begin
    o_sram_ce   = 1'b0;
    o_sram_oe   = hold_oe;
    o_sram_addr = hold_addr;
    o_sram_din  = hold_din;
    if (state == ST_INIT) begin
      o_sram_ce   = arst_n;
      o_sram_oe   = 1'b0;
      o_sram_addr = cnt;
      o_sram_din  = INIT_VAL;
    end else if (accept_p0) begin
      o_sram_ce   = 1'b1;
      o_sram_oe   = !i_req_wr;
      o_sram_addr = i_req_addr;
      o_sram_din  = i_req_din;
    end
  end

  // Sweep state machine. i_init has priority and always restarts the sweep
  // at entry 0. The cycle that writes entry N-1 moves the FSM to ACTIVE.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (i_init) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      if (last_entry) begin
        state <= ST_ACTIVE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + AW'(1);
      end
    end
  end

  // Remember the last driven direction so idle cycles can repeat it.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      hold_oe <= 1'b0;
    end else begin
      hold_oe <= o_sram_oe;
    end
  end

  // Remember the last driven address and data. These are datapath-only
  // registers, so they have no reset.
  always_ff @(posedge clk) begin
    hold_addr <= o_sram_addr;
    hold_din  <= o_sram_din;
  end

  // ---- stage p0 -> p1: the SRAM returns read data one cycle after ce ----
  // Track which cycles carry read data. On reset any pending response is
  // dropped.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_vld_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= rd_vld_p0;
    end
  end

`ifdef STK_PIPE_MEM_HEAD_CTRL_RSP_FLOP_EN
  logic         rsp_vld_p2;
  logic [W-1:0] rsp_dout_p2;

  // ---- stage p1 -> p2: optional response register ----
  // Register the response valid flag.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rsp_vld_p2 <= 1'b0;
    end else begin
      rsp_vld_p2 <= rd_vld_p1;
    end
  end

  // Register the response data. It is qualified by rsp_vld_p2, so it has no
  // reset.
  always_ff @(posedge clk) begin
    rsp_dout_p2 <= i_sram_dout;
  end

  assign o_rsp_vld  = rsp_vld_p2;
  assign o_rsp_dout = rsp_dout_p2;
`else
  assign o_rsp_vld  = rd_vld_p1;
  assign o_rsp_dout = i_sram_dout;
`endif

endmodule

// File: tb/tb_stk_pipe_mem_head_ctrl.sv
// Testbench for stk_pipe_mem_head_ctrl. It includes a behavioural SRAM and a
// cycle-level reference model. The model tracks whether a sweep is running,
// the next sweep index, a shadow copy of memory, and a queue of expected
// responses.
module tb_stk_pipe_mem_head_ctrl;
  localparam int W  = 10;
  localparam int N  = 1024;
  localparam int AW = 10;
`ifdef STK_PIPE_MEM_HEAD_CTRL_RSP_FLOP_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          arst_n = 1'b1;
  logic          i_init = 1'b0;
  logic          i_req_vld = 1'b0;
  logic          i_req_wr = 1'b0;
  logic [AW-1:0] i_req_addr = '0;
  logic [W-1:0]  i_req_din = '0;
  logic          o_req_rdy;
  logic          o_rsp_vld;
  logic [W-1:0]  o_rsp_dout;
  logic          o_busy;
  logic [AW-1:0] o_sram_addr;
  logic [W-1:0]  o_sram_din;
  logic          o_sram_ce;
  logic          o_sram_oe;
  logic [W-1:0]  i_sram_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stk_pipe_mem_head_ctrl #(.W(W), .N(N), .INIT_VAL(10'h000)) dut (
    .clk(clk), .arst_n(arst_n), .i_init(i_init),
    .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy), .i_req_wr(i_req_wr),
    .i_req_addr(i_req_addr), .i_req_din(i_req_din),
    .o_rsp_vld(o_rsp_vld), .o_rsp_dout(o_rsp_dout), .o_busy(o_busy),
    .o_sram_addr(o_sram_addr), .o_sram_din(o_sram_din),
    .o_sram_ce(o_sram_ce), .o_sram_oe(o_sram_oe), .i_sram_dout(i_sram_dout)
  );

  // Behavioural SRAM. It starts with random contents, so a missing sweep
  // write shows up.
  logic [W-1:0] sram [N];
  bit           sram_seeded = 1'b0;
  always @(posedge clk) begin
    if (!sram_seeded) begin
      for (int i = 0; i < N; i++) sram[i] = W'($urandom);
      sram_seeded = 1'b1;
    end
    if (o_sram_ce) begin
      if (o_sram_oe) i_sram_dout <= sram[o_sram_addr];
      else           sram[o_sram_addr] = o_sram_din;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  typedef struct { int due; logic [W-1:0] data; } rsp_t;
  rsp_t          rq[$];
  bit            m_busy = 1'b1;
  int            m_idx = 0;
  logic [W-1:0]  ref_mem [N];
  int            cyc = 0;
  bit            hold_known = 1'b0;
  logic          h_oe;
  logic [AW-1:0] h_addr;
  logic [W-1:0]  h_din;
  bit            m_acc;
  bit            m_exp_vld;

  // Compare on every falling edge, then advance the model to the next rising
  // edge.
  always @(negedge clk) begin
    if (!arst_n) begin
      chk("rst_busy", o_busy, 1);
      chk("rst_rdy", o_req_rdy, 0);
      chk("rst_ce", o_sram_ce, 0);
      chk("rst_rsp_vld", o_rsp_vld, 0);
      m_busy = 1'b1;
      m_idx = 0;
      rq.delete();
      hold_known = 1'b0;
    end else begin
      m_acc = !m_busy && !i_init && i_req_vld;
      chk("busy", o_busy, m_busy);
      chk("req_rdy", o_req_rdy, !m_busy && !i_init);
      if (m_busy) begin
        chk("sweep_ce", o_sram_ce, 1);
        chk("sweep_oe", o_sram_oe, 0);
        chk("sweep_addr", o_sram_addr, m_idx);
        chk("sweep_din", o_sram_din, 0);
        h_oe = 1'b0; h_addr = AW'(m_idx); h_din = '0; hold_known = 1'b1;
      end else if (m_acc) begin
        chk("req_ce", o_sram_ce, 1);
        chk("req_oe", o_sram_oe, !i_req_wr);
        chk("req_addr", o_sram_addr, i_req_addr);
        chk("req_din", o_sram_din, i_req_din);
        h_oe = !i_req_wr; h_addr = i_req_addr; h_din = i_req_din; hold_known = 1'b1;
      end else begin
        chk("idle_ce", o_sram_ce, 0);
        if (hold_known) begin
          chk("hold_oe", o_sram_oe, h_oe);
          chk("hold_addr", o_sram_addr, h_addr);
          chk("hold_din", o_sram_din, h_din);
        end
      end
      m_exp_vld = (rq.size() > 0) && (rq[0].due == cyc);
      chk("rsp_vld", o_rsp_vld, m_exp_vld);
      if (m_exp_vld) begin
        chk("rsp_dout", o_rsp_dout, rq[0].data);
        void'(rq.pop_front());
      end
      if (m_busy) begin
        ref_mem[m_idx] = '0;
        if (i_init)            m_idx = 0;
        else if (m_idx == N-1) begin m_busy = 1'b0; m_idx = 0; end
        else                   m_idx++;
      end else if (i_init) begin
        m_busy = 1'b1;
        m_idx = 0;
      end else if (m_acc) begin
        if (i_req_wr) ref_mem[i_req_addr] = i_req_din;
        else          rq.push_back('{due: cyc + LAT, data: ref_mem[i_req_addr]});
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req_vld = 1'b0; i_req_wr = 1'b0; i_init = 1'b0;
  endtask

  task automatic req(input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d);
    i_req_vld = 1'b1; i_req_wr = wr; i_req_addr = a; i_req_din = d;
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (o_busy === 1'b1 && n < 3000) begin
      step();
      n++;
    end
  endtask

  task automatic chk_reset_now(input string tag);
    chk({tag, "_busy"}, o_busy, 1);
    chk({tag, "_rdy"}, o_req_rdy, 0);
    chk({tag, "_ce"}, o_sram_ce, 0);
    chk({tag, "_rsp_vld"}, o_rsp_vld, 0);
  endtask

  logic [W-1:0] got[$];
  int           gstep[$];
  int           n;
  int           nz;

  initial begin
    #1 arst_n = 1'b0;
    #1 chk_reset_now("por");
    repeat (3) step();
    arst_n = 1'b1;

    // The initial sweep lasts exactly N cycles and leaves every entry at 0.
    wait_sweep(n);
    chk("sweep_len", n, 1024);
    nz = 0;
    for (int i = 0; i < N; i++) if (sram[i] !== 10'h000) nz++;
    chk("sweep_nonzero_entries", nz, 0);
    chk("rdy_after_sweep", o_req_rdy, 1);

    // Write, then read the same address on the next cycle.
    req(1'b1, 10'h005, 10'h2A5); step();
    req(1'b0, 10'h005, 10'h000); step();
    idle();
    repeat (LAT - 1) step();
    chk("wr_rd_vld", o_rsp_vld, 1);
    chk("wr_rd_dout", o_rsp_dout, 10'h2A5);

    // Four back-to-back reads return one response per cycle, in order.
    for (int i = 0; i < 4; i++) begin
      req(1'b1, AW'(i), W'(10'h011 + i)); step();
    end
    for (int s = 0; s < 4 + LAT + 2; s++) begin
      if (s < 4) req(1'b0, AW'(s), 10'h000);
      else       idle();
      step();
      if (o_rsp_vld) begin got.push_back(o_rsp_dout); gstep.push_back(s); end
    end
    chk("b2b_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk("b2b_dout", got[i], 10'h011 + i);
      chk("b2b_timing", gstep[i], i + LAT - 1);
    end

    // An i_init pulse blocks its own request and re-sweeps the memory.
    req(1'b1, 10'h3FF, 10'h155); step();
    req(1'b0, 10'h3FF, 10'h000); i_init = 1'b1;
    #1;
    chk("init_rdy", o_req_rdy, 0);
    chk("init_ce", o_sram_ce, 0);
    step();
    idle();
    chk("init_busy", o_busy, 1);
    wait_sweep(n);
    chk("reinit_len", n, 1024);
    req(1'b0, 10'h3FF, 10'h000); step();
    idle();
    repeat (LAT - 1) step();
    chk("reinit_vld", o_rsp_vld, 1);
    chk("reinit_dout", o_rsp_dout, 10'h000);

    // Reset while a read is in flight, then again partway through the sweep.
    req(1'b0, 10'h001, 10'h000); step();
    idle();
    arst_n = 1'b0;
    #1 chk_reset_now("rst_mid_read");
    step();
    arst_n = 1'b1;
    repeat (500) step();
    chk("cnt500_addr", o_sram_addr, 500);
    arst_n = 1'b0;
    #1 chk_reset_now("rst_mid_sweep");
    step();
    arst_n = 1'b1;
    #1;
    chk("restart_addr", o_sram_addr, 0);
    chk("restart_ce", o_sram_ce, 1);
    wait_sweep(n);
    chk("restart_len", n, 1024);

    // Random traffic. Reads are biased toward a few addresses so they hit
    // recent writes.
    for (int it = 0; it < 4000; it++) begin
      if (!arst_n) arst_n = 1'b1;
      else if ($urandom_range(0, 1999) == 0) arst_n = 1'b0;
      i_req_vld  = ($urandom_range(0, 3) != 0);
      i_req_wr   = $urandom_range(0, 1) == 1;
      i_req_addr = ($urandom_range(0, 2) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      i_req_din  = W'($urandom);
      i_init     = ($urandom_range(0, 599) == 0);
      step();
    end
    arst_n = 1'b1;
    idle();
    repeat (LAT + 2) step();
    chk("rsp_queue_drained", rq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
